// File: rtl/swan_pkg.sv
// SWAN64 shared constants: S-box tables, half-block geometry, FSM states.
// Optional build macro used by the beta blocks: INV_BETA_DUAL_MODE_EN.
package swan_pkg;

  localparam int SIDE_SIZE = 32;
  localparam int SBOX_SIZE = 4;

  localparam logic [3:0] SBOX [16] = '{
    4'h1, 4'h2, 4'hC, 4'h5, 4'h7, 4'h8, 4'hA, 4'hF,
    4'h4, 4'hD, 4'hB, 4'hE, 4'h9, 4'h6, 4'h0, 4'h3
  };

  localparam logic [3:0] INV_SBOX [16] = '{
    4'hE, 4'h0, 4'h1, 4'hF, 4'h8, 4'h3, 4'hD, 4'h4,
    4'h5, 4'hC, 4'h6, 4'hA, 4'h2, 4'h9, 4'hB, 4'h7
  };

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } state_t;

endpackage

// File: rtl/inv_sbox.sv
// Combinational inverse SWAN S-box: one 4-bit column in, one out.
module inv_sbox
  import swan_pkg::*;
(
  input  logic [3:0] i_x,
  output logic [3:0] o_y
);

  assign o_y = INV_SBOX[i_x];

endmodule

// File: rtl/inv_beta_serial.sv
// Iterative inverse SWAN64 beta layer, COLS_PER_CYCLE columns per clock.
// Build with INV_BETA_DUAL_MODE_EN to add a fwd port selecting SBOX.
module inv_beta_serial #(
  parameter int BLOCK_SIZE     = 64,
  parameter int SIDE_SIZE      = BLOCK_SIZE / 2,
  parameter int SBOX_SIZE      = 4,
  parameter int COLS_PER_CYCLE = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [0:SIDE_SIZE-1] in_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [0:SIDE_SIZE-1] out_data
`ifdef INV_BETA_DUAL_MODE_EN
  ,
  input  logic                 fwd
`endif
);

  import swan_pkg::*;

  localparam int NCOL = SIDE_SIZE / SBOX_SIZE;
  localparam int C    = COLS_PER_CYCLE;
  localparam logic [2:0] STEP = 3'(C);
  localparam logic [2:0] LAST = 3'(NCOL - C);

  if (!(C == 1 || C == 2 || C == 4 || C == 8)) begin : g_bad_cols
    $error("COLS_PER_CYCLE must be 1, 2, 4 or 8");
  end

  state_t               r_state;
  state_t               w_state_nx;
  logic [0:SIDE_SIZE-1] r_work;
  logic [0:SIDE_SIZE-1] w_work_nx;
  logic [2:0]           r_cnt;
  logic [2:0]           w_cnt_nx;
  logic                 w_last;

  logic [2:0] w_idx [C];
  logic [3:0] w_col [C];
  logic [3:0] w_sub [C];
  logic [3:0] w_res [C];

`ifdef INV_BETA_DUAL_MODE_EN
  logic r_fwd;
  logic w_fwd_nx;
`endif

  assign w_last = (r_cnt == LAST);

  for (genvar g = 0; g < C; g++) begin : g_col
    assign w_idx[g] = r_cnt + 3'(g);
    assign w_col[g] = {
      r_work[5'(w_idx[g])],
      r_work[5'(w_idx[g]) + 5'd8],
      r_work[5'(w_idx[g]) + 5'd16],
      r_work[5'(w_idx[g]) + 5'd24]
    };

    inv_sbox u_inv_sbox (
      .i_x (w_col[g]),
      .o_y (w_sub[g])
    );

`ifdef INV_BETA_DUAL_MODE_EN
    assign w_res[g] = r_fwd ? SBOX[w_col[g]] : w_sub[g];
`else
    assign w_res[g] = w_sub[g];
`endif
  end

  always_comb begin
    w_state_nx = r_state;
    w_work_nx  = r_work;
    w_cnt_nx   = r_cnt;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
`ifdef INV_BETA_DUAL_MODE_EN
    w_fwd_nx   = r_fwd;
`endif
    unique case (r_state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          w_work_nx  = in_data;
          w_cnt_nx   = '0;
          w_state_nx = BUSY;
`ifdef INV_BETA_DUAL_MODE_EN
          w_fwd_nx   = fwd;
`endif
        end
      end
      BUSY: begin
        for (int g = 0; g < C; g++) begin
          for (int r = 0; r < 4; r++) begin
            w_work_nx[5'(w_idx[g]) + 5'(8 * r)] = w_res[g][3-r];
          end
        end
        // Counter parks on the last group; it is cleared on the next accept.
        if (w_last) begin
          w_state_nx = DONE;
        end else begin
          w_cnt_nx = r_cnt + STEP;
        end
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) begin
          w_state_nx = IDLE;
        end
      end
      default: w_state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_work  <= '0;
      r_cnt   <= '0;
`ifdef INV_BETA_DUAL_MODE_EN
      r_fwd   <= 1'b0;
`endif
    end else begin
      r_state <= w_state_nx;
      r_work  <= w_work_nx;
      r_cnt   <= w_cnt_nx;
`ifdef INV_BETA_DUAL_MODE_EN
      r_fwd   <= w_fwd_nx;
`endif
    end
  end

  assign out_data = r_work;

endmodule

// File: tb/tb_inv_beta_serial.sv
// Self-checking bench for inv_beta_serial at COLS_PER_CYCLE = 1, 2, 4, 8.
// Covers INV_BETA_DUAL_MODE_EN when the macro is defined.
module tb_inv_beta_serial;

  localparam logic [3:0] SB [16] = '{
    4'h1, 4'h2, 4'hC, 4'h5, 4'h7, 4'h8, 4'hA, 4'hF,
    4'h4, 4'hD, 4'hB, 4'hE, 4'h9, 4'h6, 4'h0, 4'h3
  };
  localparam logic [3:0] IB [16] = '{
    4'hE, 4'h0, 4'h1, 4'hF, 4'h8, 4'h3, 4'hD, 4'h4,
    4'h5, 4'hC, 4'h6, 4'hA, 4'h2, 4'h9, 4'hB, 4'h7
  };
  localparam int LAT [4] = '{9, 5, 3, 2};

  typedef struct {
    logic [31:0] din;
    logic [31:0] exp;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [0:31] din;
  logic        iv   [4];
  logic        ordy [4];
  logic        ird  [4];
  logic        ov   [4];
  logic [0:31] od   [4];
`ifdef INV_BETA_DUAL_MODE_EN
  logic        fwd;
`endif

  int n_chk = 0;
  int n_err = 0;
  vec_t tv [16];

  always #5 clk = ~clk;

  inv_beta_serial #(.COLS_PER_CYCLE(1)) u_c1 (
    .clk(clk), .rst(rst),
    .in_valid(iv[0]), .in_ready(ird[0]), .in_data(din),
    .out_valid(ov[0]), .out_ready(ordy[0]), .out_data(od[0])
`ifdef INV_BETA_DUAL_MODE_EN
    , .fwd(fwd)
`endif
  );
  inv_beta_serial #(.COLS_PER_CYCLE(2)) u_c2 (
    .clk(clk), .rst(rst),
    .in_valid(iv[1]), .in_ready(ird[1]), .in_data(din),
    .out_valid(ov[1]), .out_ready(ordy[1]), .out_data(od[1])
`ifdef INV_BETA_DUAL_MODE_EN
    , .fwd(fwd)
`endif
  );
  inv_beta_serial #(.COLS_PER_CYCLE(4)) u_c4 (
    .clk(clk), .rst(rst),
    .in_valid(iv[2]), .in_ready(ird[2]), .in_data(din),
    .out_valid(ov[2]), .out_ready(ordy[2]), .out_data(od[2])
`ifdef INV_BETA_DUAL_MODE_EN
    , .fwd(fwd)
`endif
  );
  inv_beta_serial #(.COLS_PER_CYCLE(8)) u_c8 (
    .clk(clk), .rst(rst),
    .in_valid(iv[3]), .in_ready(ird[3]), .in_data(din),
    .out_valid(ov[3]), .out_ready(ordy[3]), .out_data(od[3])
`ifdef INV_BETA_DUAL_MODE_EN
    , .fwd(fwd)
`endif
  );

  function automatic logic [0:31] beta(input logic [0:31] x, input bit f);
    logic [0:31] y;
    logic [3:0]  n;
    y = x;
    for (int j = 0; j < 8; j++) begin
      n = {x[j], x[j+8], x[j+16], x[j+24]};
      n = f ? SB[n] : IB[n];
      y[j]    = n[3];
      y[j+8]  = n[2];
      y[j+16] = n[1];
      y[j+24] = n[0];
    end
    return y;
  endfunction

  task automatic chk(input string nm, input logic [31:0] a,
                     input logic [31:0] e);
    n_chk++;
    if (a !== e) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, a, e);
    end
  endtask

  task automatic wait_ready(input int k);
    int n;
    n = 0;
    while (!ird[k] && n < 20) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic run_blk(input int k, input logic [31:0] d,
                         input logic [31:0] e, input string nm);
    int lat;
    din = d;
    iv[k] = 1'b1;
    ordy[k] = 1'b1;
    wait_ready(k);
    if (!ird[k]) begin
      chk({nm, " accept"}, 32'(ird[k]), 32'd1);
      iv[k] = 1'b0;
      return;
    end
    @(posedge clk);
    #1 iv[k] = 1'b0;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!ov[k] && lat < 20);
    chk({nm, " lat"}, 32'(lat), 32'(LAT[k]));
    chk({nm, " data"}, od[k], e);
    @(posedge clk);
    #1 ordy[k] = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    logic [31:0] rt;
    logic [31:0] bd [3];
    int acc [3];
    int nacc;
    int nout;
    int cyc;
    int lat;
    bit seen;
    bit take;

    tv[0]  = '{32'h0000_0000, 32'hFFFF_FF00};
    tv[1]  = '{32'h0000_00FF, 32'h0000_0000};
    tv[2]  = '{32'h0000_FF00, 32'h0000_00FF};
    tv[3]  = '{32'h0000_FFFF, 32'hFFFF_FFFF};
    tv[4]  = '{32'h00FF_0000, 32'hFF00_0000};
    tv[5]  = '{32'h00FF_00FF, 32'h0000_FFFF};
    tv[6]  = '{32'h00FF_FF00, 32'hFFFF_00FF};
    tv[7]  = '{32'h00FF_FFFF, 32'h00FF_0000};
    tv[8]  = '{32'hFF00_0000, 32'h00FF_00FF};
    tv[9]  = '{32'hFF00_00FF, 32'hFFFF_0000};
    tv[10] = '{32'hFF00_FF00, 32'h00FF_FF00};
    tv[11] = '{32'hFF00_FFFF, 32'hFF00_FF00};
    tv[12] = '{32'hFFFF_0000, 32'h0000_FF00};
    tv[13] = '{32'hFFFF_00FF, 32'hFF00_00FF};
    tv[14] = '{32'hFFFF_FF00, 32'hFF00_FFFF};
    tv[15] = '{32'hFFFF_FFFF, 32'h00FF_FFFF};

    rst = 1'b1;
    din = '0;
    for (int k = 0; k < 4; k++) begin
      iv[k] = 1'b0;
      ordy[k] = 1'b0;
    end
`ifdef INV_BETA_DUAL_MODE_EN
    fwd = 1'b0;
`endif
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    for (int k = 0; k < 4; k++) begin
      chk($sformatf("rst in_ready c%0d", k), 32'(ird[k]), 32'd1);
      chk($sformatf("rst out_valid c%0d", k), 32'(ov[k]), 32'd0);
      chk($sformatf("rst out_data c%0d", k), od[k], 32'd0);
    end

    for (int k = 0; k < 4; k++) begin
      for (int i = 0; i < 16; i++) begin
        run_blk(k, tv[i].din, tv[i].exp, $sformatf("col%0d c%0d", i, k));
      end
    end

    rt = beta(32'h0123_4567, 1'b1);
    for (int k = 0; k < 4; k++) begin
      run_blk(k, rt, 32'h0123_4567, $sformatf("roundtrip c%0d", k));
    end
    run_blk(1, 32'hDEAD_BEEF, beta(32'hDEAD_BEEF, 1'b0), "mixed c1");

    // back-pressure on the COLS_PER_CYCLE = 2 instance
    din = 32'h0000_FFFF;
    iv[1] = 1'b1;
    ordy[1] = 1'b0;
    wait_ready(1);
    @(posedge clk);
    #1 iv[1] = 1'b0;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!ov[1] && lat < 20);
    chk("bp lat", 32'(lat), 32'd5);
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      chk("bp out_valid", 32'(ov[1]), 32'd1);
      chk("bp out_data", od[1], 32'hFFFF_FFFF);
      chk("bp in_ready", 32'(ird[1]), 32'd0);
    end
    ordy[1] = 1'b1;
    @(posedge clk);
    #1 ordy[1] = 1'b0;
    @(negedge clk);
    chk("bp release in_ready", 32'(ird[1]), 32'd1);
    chk("bp release out_valid", 32'(ov[1]), 32'd0);

    // reset one cycle after accept
    din = 32'h0123_4567;
    iv[1] = 1'b1;
    ordy[1] = 1'b1;
    wait_ready(1);
    @(posedge clk);
    #1 iv[1] = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst in_ready", 32'(ird[1]), 32'd1);
    chk("midrst out_valid", 32'(ov[1]), 32'd0);
    chk("midrst out_data", od[1], 32'd0);
    rst = 1'b0;
    seen = 1'b0;
    repeat (12) begin
      @(negedge clk);
      if (ov[1]) seen = 1'b1;
    end
    chk("midrst no out_valid", 32'(seen), 32'd0);

    // back-to-back with in_valid held high
    bd[0] = 32'h1234_5678;
    bd[1] = 32'h9ABC_DEF0;
    bd[2] = 32'h0F1E_2D3C;
    nacc = 0;
    nout = 0;
    cyc = 0;
    din = bd[0];
    iv[1] = 1'b1;
    ordy[1] = 1'b1;
    while (cyc < 60 && nout < 3) begin
      take = ird[1] && iv[1];
      if (take) begin
        acc[nacc] = cyc;
        nacc++;
      end
      if (ov[1]) begin
        chk($sformatf("b2b data %0d", nout), od[1], beta(bd[nout], 1'b0));
        nout++;
      end
      @(posedge clk);
      #1;
      if (take) begin
        if (nacc < 3) din = bd[nacc];
        else iv[1] = 1'b0;
      end
      @(negedge clk);
      cyc++;
    end
    iv[1] = 1'b0;
    ordy[1] = 1'b0;
    chk("b2b count", 32'(nout), 32'd3);
    if (nacc == 3) begin
      chk("b2b spacing 0-1", 32'(acc[1] - acc[0]), 32'd6);
      chk("b2b spacing 1-2", 32'(acc[2] - acc[1]), 32'd6);
    end else begin
      chk("b2b accepts", 32'(nacc), 32'd3);
    end

`ifdef INV_BETA_DUAL_MODE_EN
    @(negedge clk);
    fwd = 1'b1;
    run_blk(1, 32'h0123_4567, beta(32'h0123_4567, 1'b1), "dual fwd");
    rt = od[1];
    fwd = 1'b0;
    run_blk(1, rt, 32'h0123_4567, "dual inv");
`endif

    repeat (2) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
